// File: rtl/pipe_controller.sv
// -----------------------------------------------------------------------------
// pipe_controller
//
// Control unit for the 5-stage MIPS pipeline. It decodes the instruction in ID
// and carries its control bundle through the ID/EX, EX/MEM and MEM/WB
// registers. It also detects load-use hazards, redirects J in ID, and resolves
// BEQ/BNE in EX or MEM, squashing younger instructions when a branch is taken.
//
// Parameters
//   PC_W           PC width (at least 28)
//   BRANCH_IN_MEM  0: BEQ/BNE resolved in EX, 1: resolved in MEM
//   HAZARD_EN      1: load-use detection active, 0: stall_o tied low
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   id_valid_i       ID holds a real instruction
//   id_inst_i        instruction in ID
//   id_pc4_i         PC+4 of the ID instruction
//   br_zero_i        ALU zero flag of the instruction in the resolve stage
//   stall_o          hold PC and IF/ID (combinational)
//   flush_ifid_o     turn IF/ID into a bubble (combinational)
//   redirect_o       load PC from redirect_pc_o (combinational)
//   redirect_pc_o    jump target
//   branch_taken_o   taken branch in the resolve stage (combinational)
//   ex_ctrl_o        {RegDst, ALUsrc, ALUop[4:0]} of EX
//   mem_ctrl_o       {BNE, BEQ, MemRead, MemWrite} of MEM
//   wb_ctrl_o        {RegWrite, MemToReg} of WB
//   *_valid_o        stage valid flags
//   *_dst_o          destination register per stage
// -----------------------------------------------------------------------------
module pipe_controller #(
    parameter int PC_W          = 32,
    parameter bit BRANCH_IN_MEM = 1'b0,
    parameter bit HAZARD_EN     = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid_i,
    input  logic [31:0]     id_inst_i,
    input  logic [PC_W-1:0] id_pc4_i,
    input  logic            br_zero_i,
    output logic            stall_o,
    output logic            flush_ifid_o,
    output logic            redirect_o,
    output logic [PC_W-1:0] redirect_pc_o,
    output logic            branch_taken_o,
    output logic [6:0]      ex_ctrl_o,
    output logic [3:0]      mem_ctrl_o,
    output logic [1:0]      wb_ctrl_o,
    output logic            ex_valid_o,
    output logic            mem_valid_o,
    output logic            wb_valid_o,
    output logic [4:0]      ex_dst_o,
    output logic [4:0]      mem_dst_o,
    output logic [4:0]      wb_dst_o
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_OR  = 6'b100101;

    localparam logic [4:0] ALU_ADD  = 5'b00001;
    localparam logic [4:0] ALU_SUB  = 5'b00010;
    localparam logic [4:0] ALU_AND  = 5'b00100;
    localparam logic [4:0] ALU_SLT  = 5'b01000;
    localparam logic [4:0] ALU_OR   = 5'b10000;
    localparam logic [4:0] ALU_NONE = 5'b11111;

    // mem field layout: {BNE, BEQ, MemRead, MemWrite}
    typedef struct packed {
        logic       valid;
        logic [6:0] ex;
        logic [3:0] mem;
        logic [1:0] wb;
        logic [4:0] dst;
    } idex_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] mem;
        logic [1:0] wb;
        logic [4:0] dst;
    } exmem_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] wb;
        logic [4:0] dst;
    } memwb_t;

    localparam idex_t  IDEX_BUBBLE  = {1'b0, 2'b00, ALU_NONE, 4'b0000, 2'b00, 5'd0};
    localparam exmem_t EXMEM_BUBBLE = {1'b0, 4'b0000, 2'b00, 5'd0};
    localparam memwb_t MEMWB_BUBBLE = {1'b0, 2'b00, 5'd0};

    idex_t  idex_q,  idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;

    // ------------------------------------------------------------------
    // Decode of the ID instruction
    // ------------------------------------------------------------------
    logic [5:0] id_op;
    logic [5:0] id_funct;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_rd;

    assign id_op    = id_inst_i[31:26];
    assign id_funct = id_inst_i[5:0];
    assign id_rs    = id_inst_i[25:21];
    assign id_rt    = id_inst_i[20:16];
    assign id_rd    = id_inst_i[15:11];

    logic       dec_reg_dst;
    logic       dec_alu_src;
    logic [4:0] dec_alu_op;
    logic       dec_bne;
    logic       dec_beq;
    logic       dec_mem_read;
    logic       dec_mem_write;
    logic       dec_reg_write;
    logic       dec_mem_to_reg;
    logic       dec_reads_rs;
    logic       dec_reads_rt;
    logic       dec_is_j;
    logic [4:0] dec_dst;

    always_comb begin
        dec_reg_dst    = 1'b0;
        dec_alu_src    = 1'b0;
        dec_alu_op     = ALU_NONE;
        dec_bne        = 1'b0;
        dec_beq        = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_reads_rs   = 1'b0;
        dec_reads_rt   = 1'b0;
        dec_is_j       = 1'b0;

        case (id_op)
            OP_RTYPE: begin
                dec_reg_dst  = 1'b1;
                dec_reads_rs = 1'b1;
                dec_reads_rt = 1'b1;
                dec_reg_write = 1'b1;
                case (id_funct)
                    FN_ADD:  dec_alu_op = ALU_ADD;
                    FN_SUB:  dec_alu_op = ALU_SUB;
                    FN_AND:  dec_alu_op = ALU_AND;
                    FN_SLT:  dec_alu_op = ALU_SLT;
                    FN_OR:   dec_alu_op = ALU_OR;
                    default: begin
                        // Unsupported funct: keep the ALU idle and never write.
                        dec_alu_op    = ALU_NONE;
                        dec_reg_write = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                dec_alu_src    = 1'b1;
                dec_alu_op     = ALU_ADD;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_reg_write  = 1'b1;
                dec_reads_rs   = 1'b1;
            end
            OP_SW: begin
                dec_alu_src   = 1'b1;
                dec_alu_op    = ALU_ADD;
                dec_mem_write = 1'b1;
                dec_reads_rs  = 1'b1;
                dec_reads_rt  = 1'b1;
            end
            OP_BEQ: begin
                dec_alu_op   = ALU_SUB;
                dec_beq      = 1'b1;
                dec_reads_rs = 1'b1;
                dec_reads_rt = 1'b1;
            end
            OP_BNE: begin
                dec_alu_op   = ALU_SUB;
                dec_bne      = 1'b1;
                dec_reads_rs = 1'b1;
                dec_reads_rt = 1'b1;
            end
            OP_J: begin
                dec_alu_op = 5'b00000;
                dec_is_j   = 1'b1;
            end
            default: begin
            end
        endcase

        // A non-writing instruction reports register 0 so it can never
        // alias with a real dependency.
        if (!dec_reg_write) begin
            dec_dst = 5'd0;
        end else if (dec_reg_dst) begin
            dec_dst = id_rd;
        end else begin
            dec_dst = id_rt;
        end
    end

    // ------------------------------------------------------------------
    // Branch resolution
    // ------------------------------------------------------------------
    logic res_valid;
    logic res_beq;
    logic res_bne;

    generate
        if (BRANCH_IN_MEM) begin : g_res_mem
            assign res_valid = exmem_q.valid;
            assign res_beq   = exmem_q.mem[2];
            assign res_bne   = exmem_q.mem[3];
        end else begin : g_res_ex
            assign res_valid = idex_q.valid;
            assign res_beq   = idex_q.mem[2];
            assign res_bne   = idex_q.mem[3];
        end
    endgenerate

    assign branch_taken_o = res_valid & ((res_beq & br_zero_i) | (res_bne & ~br_zero_i));

    // ------------------------------------------------------------------
    // Load-use hazard. ex_dst_o of a load is its rt, so matching against it
    // catches a consumer that sits directly behind the load.
    // ------------------------------------------------------------------
    logic load_use;

    generate
        if (HAZARD_EN) begin : g_hazard
            assign load_use = id_valid_i & idex_q.valid & idex_q.mem[1]
                            & (idex_q.dst != 5'd0)
                            & ((dec_reads_rs & (id_rs == idex_q.dst))
                             | (dec_reads_rt & (id_rt == idex_q.dst)));
        end else begin : g_no_hazard
            logic unused_hazard;
            assign unused_hazard = dec_reads_rs ^ dec_reads_rt ^ (^id_rs) ^ (^id_rt);
            assign load_use      = 1'b0;
        end
    endgenerate

    // A taken branch squashes the ID instruction anyway, so it overrides
    // both the stall and the jump.
    assign stall_o      = load_use & ~branch_taken_o;
    assign redirect_o   = id_valid_i & dec_is_j & ~stall_o & ~branch_taken_o;
    assign flush_ifid_o = branch_taken_o | redirect_o;

    generate
        if (PC_W > 28) begin : g_pc_hi
            logic unused_pc4;
            assign unused_pc4    = ^id_pc4_i[27:0];
            assign redirect_pc_o = {id_pc4_i[PC_W-1:28], id_inst_i[25:0], 2'b00};
        end else begin : g_pc_narrow
            logic unused_pc4;
            assign unused_pc4    = ^id_pc4_i;
            assign redirect_pc_o = {id_inst_i[25:0], 2'b00};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pipeline advance
    // ------------------------------------------------------------------
    always_comb begin
        // A jump completes in ID by redirecting the PC, so it never occupies
        // a later stage and enters ID/EX as a bubble.
        if (stall_o || branch_taken_o || !id_valid_i || dec_is_j) begin
            idex_d = IDEX_BUBBLE;
        end else begin
            idex_d.valid = 1'b1;
            idex_d.ex    = {dec_reg_dst, dec_alu_src, dec_alu_op};
            idex_d.mem   = {dec_bne, dec_beq, dec_mem_read, dec_mem_write};
            idex_d.wb    = {dec_reg_write, dec_mem_to_reg};
            idex_d.dst   = dec_dst;
        end

        // With late resolution the instruction in EX is also on the wrong path.
        if (BRANCH_IN_MEM && branch_taken_o) begin
            exmem_d = EXMEM_BUBBLE;
        end else begin
            exmem_d.valid = idex_q.valid;
            exmem_d.mem   = idex_q.mem;
            exmem_d.wb    = idex_q.wb;
            exmem_d.dst   = idex_q.dst;
        end

        memwb_d.valid = exmem_q.valid;
        memwb_d.wb    = exmem_q.wb;
        memwb_d.dst   = exmem_q.dst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q  <= IDEX_BUBBLE;
            exmem_q <= EXMEM_BUBBLE;
            memwb_q <= MEMWB_BUBBLE;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign ex_ctrl_o   = idex_q.ex;
    assign ex_valid_o  = idex_q.valid;
    assign ex_dst_o    = idex_q.dst;
    assign mem_ctrl_o  = exmem_q.mem;
    assign mem_valid_o = exmem_q.valid;
    assign mem_dst_o   = exmem_q.dst;
    assign wb_ctrl_o   = memwb_q.wb;
    assign wb_valid_o  = memwb_q.valid;
    assign wb_dst_o    = memwb_q.dst;

endmodule
